param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8: number of entries; power of two, 2 to 256.
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 8: data word width in bits.
REQ-003 The block SHALL have parameter AF_LEVEL, default FIFO_DEPTH-2: almost_full threshold, legal range 1..FIFO_DEPTH.
REQ-004 The block SHALL have parameter AE_LEVEL, default 1: almost_empty threshold, legal range 0..FIFO_DEPTH-1.
REQ-005 The block SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1: single clock; all logic on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- w_en, in, 1: write request.
- data_in, in, FIFO_WIDTH: write data.
- r_en, in, 1: read request (FWFT=1: pop acknowledge).
- flush, in, 1: synchronous clear of contents.
- clr_err, in, 1: clears sticky error flags.
- data_out, out, FIFO_WIDTH: read data.
- full, out, 1: count == FIFO_DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= AF_LEVEL.
- almost_empty, out, 1: count <= AE_LEVEL.
- count, out, clog2(FIFO_DEPTH)+1: current occupancy.
- overflow, out, 1: sticky; a write was attempted while full.
- underflow, out, 1: sticky; a read was attempted while empty.

Function
REQ-007 A write SHALL be accepted at a rising edge iff w_en=1, full=0 and flush=0; data_in is stored at the write pointer, which then increments modulo FIFO_DEPTH.
REQ-008 A read SHALL be accepted at a rising edge iff r_en=1, empty=0 and flush=0; the read pointer then increments modulo FIFO_DEPTH.
REQ-009 Acceptance SHALL be evaluated on the flag values present before the edge; a simultaneous read and write on a full FIFO accepts only the read, and on an empty FIFO accepts only the write.
REQ-010 count SHALL change as follows: +1 on write-only, -1 on read-only, and unchanged when both or neither are accepted; it never exceeds FIFO_DEPTH and never goes below 0.
REQ-011 full, empty, almost_full and almost_empty SHALL be pure functions of the registered count, and therefore update in the same cycle as count.
REQ-012 With FWFT=0, an accepted read SHALL load the head entry into the data_out register at that edge (one-cycle latency); otherwise data_out holds its value.
REQ-013 With FWFT=1, data_out SHALL present the head entry whenever empty=0 and SHALL be 0 when empty=1; a write into an empty FIFO is visible in the cycle after the write edge.
REQ-014 flush=1 SHALL, at the edge, zero both pointers and count, override w_en and r_en, and leave data_out unchanged when FWFT=0.
REQ-015 overflow SHALL set on any edge with w_en=1, full=1 and flush=0; underflow SHALL set on any edge with r_en=1, empty=1 and flush=0.
REQ-016 clr_err=1 SHALL clear both sticky flags at the edge, and a set condition in the same cycle SHALL take priority over the clear.
REQ-017 Pointer wrap SHALL be seamless, with no bubble cycle and no loss of order across the DEPTH-1 to 0 boundary.
REQ-018 Storage SHALL be a FIFO_DEPTH x FIFO_WIDTH array that is not reset; stale contents are never observable on data_out.

Reset
REQ-019 rst_n=0 SHALL immediately, without a clock, force the following: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-020 Reset asserted mid-operation SHALL discard all contents, and the first write after rst_n rises SHALL be read back first.

Verification
REQ-021 The bench SHALL cover the scenarios below, using DEPTH=8, WIDTH=8, AF=6, AE=1 unless stated otherwise:
- Reset: rst_n low with no clock -> all outputs at REQ-019 values.
- Fill, FWFT=0: write 0x11..0x88 -> almost_full=1 after the 6th write, full=1 and count=8 after the 8th; a 9th write of 0x99 -> overflow=1, count=8; 8 reads -> 0x11..0x88 appear one cycle after each accepted read; then empty=1.
- Simultaneous: at count=4, w_en=r_en=1 for 3 cycles -> count stays 4 and order is preserved; from empty, w_en=r_en=1 -> count=1, underflow=1, and the written word is the next read.
- Wrap: 20 interleaved single writes and reads of 0x00..0x13 -> in-order readback, count never exceeds 1.
- Flush and clear: at count=5, flush=1 with w_en=1 -> count=0, empty=1, and the write is dropped; clr_err=1 together with an overflow condition -> overflow stays 1.
- FWFT=1: write 0xA5 into an empty FIFO -> the next cycle shows empty=0 and data_out=0xA5 without r_en; r_en=1 -> empty=1 and data_out=0.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with programmable thresholds, sticky error flags
// and a choice of registered or first-word-fall-through read data.
module param_sync_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          w_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          r_en,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses the flags as they stand before the edge.
    assign wr_ok = w_en && !full && !flush;
    assign rd_ok = r_en && !empty && !flush;

    assign full         = (count == CW'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)
                count <= count + 1'b1;
            else if (rd_ok && !wr_ok)
                count <= count - 1'b1;
        end
    end

    // A fresh error in the same cycle outranks the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full && !flush)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (r_en && empty && !flush)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    dout_q <= '0;
                else if (rd_ok)
                    dout_q <= mem[rd_ptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: a registered-read FIFO and a FWFT FIFO on shared
// inputs, checked against hand-computed vectors and sequences.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n;
    logic       w_en, r_en, flush, clr_err;
    logic [7:0] data_in;

    logic [7:0] d0_dout, d1_dout;
    logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
    logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
    logic [3:0] d0_count, d1_count;

    int checks = 0;
    int errors = 0;

    always #5 if (clk_en) clk = ~clk;

    param_sync_fifo #(
        .FIFO_DEPTH(8), .FIFO_WIDTH(8),
        .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en),
        .data_in(data_in), .r_en(r_en), .flush(flush),
        .clr_err(clr_err), .data_out(d0_dout),
        .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae),
        .count(d0_count), .overflow(d0_ovf),
        .underflow(d0_unf)
    );

    param_sync_fifo #(
        .FIFO_DEPTH(8), .FIFO_WIDTH(8),
        .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en),
        .data_in(data_in), .r_en(r_en), .flush(flush),
        .clr_err(clr_err), .data_out(d1_dout),
        .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae),
        .count(d1_count), .overflow(d1_ovf),
        .underflow(d1_unf)
    );

    typedef struct {
        logic       w, r, fl, ce;
        logic [7:0] d;
        logic [3:0] cnt;
        logic       full, empty, af, ae, ovf, unf;
        logic [7:0] dout;
    } vec_t;

    vec_t vt[$];

    function automatic logic [9:0] st0();
        return {d0_count, d0_full, d0_empty, d0_af,
                d0_ae, d0_ovf, d0_unf};
    endfunction

    function automatic logic [9:0] stv(vec_t v);
        return {v.cnt, v.full, v.empty, v.af,
                v.ae, v.ovf, v.unf};
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r,
                         input logic fl, input logic ce,
                         input logic [7:0] d);
        w_en = w; r_en = r; flush = fl;
        clr_err = ce; data_in = d;
        @(posedge clk);
        @(negedge clk);
        w_en = 0; r_en = 0; flush = 0;
        clr_err = 0; data_in = 8'h00;
    endtask

    initial begin
        int c;
        w_en = 0; r_en = 0; flush = 0;
        clr_err = 0; data_in = 8'h00;

        // Fill, overflow, drain, underflow and sticky-clear table
        for (int k = 1; k <= 8; k++)
            vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'(k * 17),
                4'(k), (k == 8), 1'b0, (k >= 6), (k <= 1),
                1'b0, 1'b0, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h99, 4'd8,
            1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
        for (int j = 1; j <= 8; j++) begin
            c = 8 - j;
            vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,
                4'(c), 1'b0, (c == 0), (c >= 6), (c <= 1),
                1'b1, 1'b0, 8'(j * 17)});
        end
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0,
            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h88});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0,
            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h88});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0,
            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h88});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0,
            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h88});

        // Reset with no clock running
        rst_n = 1'b0;
        #2;
        chk("rst_status", int'(st0()), int'(10'b0000_010100));
        chk("rst_dout", int'(d0_dout), 0);
        chk("rst_fwft_empty", int'(d1_empty), 1);
        chk("rst_fwft_dout", int'(d1_dout), 0);
        #3 rst_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            drive(vt[i].w, vt[i].r, vt[i].fl, vt[i].ce, vt[i].d);
            chk($sformatf("vec%0d_status", i),
                int'(st0()), int'(stv(vt[i])));
            chk($sformatf("vec%0d_dout", i),
                int'(d0_dout), int'(vt[i].dout));
        end

        // Simultaneous read/write at count=4
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 0, 8'(8'hA0 + i));
        chk("sim_pre_count", int'(d0_count), 4);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 8'(8'hB0 + i));
            chk($sformatf("sim%0d_count", i), int'(d0_count), 4);
            chk($sformatf("sim%0d_dout", i),
                int'(d0_dout), int'(8'hA0 + i));
        end
        drive(0, 1, 0, 0, 8'h00);
        chk("sim_tail0", int'(d0_dout), 8'hA3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 8'h00);
            chk($sformatf("sim_tail%0d", i + 1),
                int'(d0_dout), int'(8'hB0 + i));
        end
        chk("sim_empty", int'(d0_empty), 1);

        // Simultaneous read/write on empty
        drive(1, 1, 0, 0, 8'hC7);
        chk("se_count", int'(d0_count), 1);
        chk("se_unf", int'(d0_unf), 1);
        drive(0, 1, 0, 0, 8'h00);
        chk("se_dout", int'(d0_dout), 8'hC7);
        chk("se_count2", int'(d0_count), 0);
        drive(0, 0, 0, 1, 8'h00);
        chk("se_clr", int'(d0_unf), 0);

        // Interleaved traffic wrapping the pointers
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 8'(i));
            chk($sformatf("wrap%0d_count", i), int'(d0_count), 1);
            drive(0, 1, 0, 0, 8'h00);
            chk($sformatf("wrap%0d_dout", i), int'(d0_dout), i);
        end
        chk("wrap_ovf_unf", int'({d0_ovf, d0_unf}), 0);

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++)
            drive(1, 0, 0, 0, 8'(8'h51 + i));
        chk("fl_pre_count", int'(d0_count), 5);
        drive(1, 0, 1, 0, 8'hEE);
        chk("fl_status", int'(st0()), int'(10'b0000_010100));
        chk("fl_dout_hold", int'(d0_dout), 8'h13);
        drive(1, 0, 0, 0, 8'h5A);
        drive(0, 1, 0, 0, 8'h00);
        chk("fl_next", int'(d0_dout), 8'h5A);

        // Clear loses to a same-cycle overflow
        for (int i = 0; i < 8; i++)
            drive(1, 0, 0, 0, 8'(8'h60 + i));
        chk("ov_full", int'(d0_full), 1);
        drive(1, 0, 0, 1, 8'h77);
        chk("ov_pri", int'(d0_ovf), 1);
        chk("ov_count", int'(d0_count), 8);
        drive(0, 0, 0, 1, 8'h00);
        chk("ov_clr", int'(d0_ovf), 0);

        // Asynchronous reset mid-operation
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_status", int'(st0()), int'(10'b0000_010100));
        chk("mr_dout", int'(d0_dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 8'h3C);
        drive(1, 0, 0, 0, 8'h3D);
        drive(0, 1, 0, 0, 8'h00);
        chk("mr_first", int'(d0_dout), 8'h3C);

        // First-word-fall-through instance
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("fw_rst_empty", int'(d1_empty), 1);
        chk("fw_rst_dout", int'(d1_dout), 0);
        drive(1, 0, 0, 0, 8'hA5);
        chk("fw_empty", int'(d1_empty), 0);
        chk("fw_dout", int'(d1_dout), 8'hA5);
        drive(0, 1, 0, 0, 8'h00);
        chk("fw_pop_empty", int'(d1_empty), 1);
        chk("fw_pop_dout", int'(d1_dout), 0);
        drive(1, 0, 0, 0, 8'h01);
        drive(1, 0, 0, 0, 8'h02);
        chk("fw_head", int'(d1_dout), 8'h01);
        drive(0, 1, 0, 0, 8'h00);
        chk("fw_next", int'(d1_dout), 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
